multi_pulse_gen: RTL and testbench
==================================

# multi_pulse_gen

Parametrised multi-channel pulse generator sharing one millisecond prescaler across NUM_CH independent channels. Each channel runs in one of four modes: off, square-wave, PWM, or retriggerable-blocked one-shot. Channel outputs drive the project's indicator and actuator pins. Period and width registers are supplied by the bus-side register block.

## Interface
- CNT_MAX, 100_000: clk cycles per millisecond tick, ≥ 2.
- NUM_CH, 4: number of channels, 1–16.
- MSW, 16: width of per-channel millisecond fields.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- mode  in  2*NUM_CH  per-channel mode, channel i at [2i+1:2i]: 00 OFF, 01 SQUARE, 10 PWM, 11 ONESHOT.
- period_ms  in  MSW*NUM_CH  per-channel period in ms, channel i at [MSW*i +: MSW].
- high_ms  in  MSW*NUM_CH  per-channel high time in ms (PWM, ONESHOT).
- trig  in  NUM_CH  one-shot triggers, already synchronous to clk.
- pulse_out  out  NUM_CH  registered channel outputs.
- done  out  NUM_CH  one-cycle strobe at the end of each one-shot.

## Operation
- Prescaler:
  - tick_cnt counts 0..CNT_MAX-1 and wraps. It free-runs whenever reset is low.
  - ms_tick is combinational and high in the cycle where tick_cnt == CNT_MAX-1.
- Per channel state: ms_cnt (MSW bits), out register, trig_d (previous trig), prev_mode.
- Mode change (mode ≠ prev_mode):
  - In that cycle, ms_cnt←0, out←0, done←0.
  - Normal behaviour resumes the next cycle.
- Config fields are live, not shadowed.
- Wrap compare uses ms_cnt ≥ period_ms-1, so a period shrunk below the current count wraps on the next ms_tick.
- OFF:
  - ms_cnt←0, out←0.
  - Triggers are ignored.
- SQUARE:
  - If period_ms == 0: out←0, ms_cnt←0.
  - Otherwise, on ms_tick: if ms_cnt ≥ period_ms-1, then ms_cnt←0 and out toggles; else ms_cnt++.
  - Each half-period is exactly period_ms ms, so the full cycle is 2·period_ms ms.
- PWM:
  - If period_ms == 0: out←0, ms_cnt←0.
  - Otherwise ms_cnt wraps as in SQUARE, without the toggle.
  - Every cycle, out←(ms_cnt_next < high_ms).
  - high_ms == 0 gives constant 0.
  - high_ms ≥ period_ms gives constant 1.
- ONESHOT:
  - A trigger edge is trig & ~trig_d.
  - Idle (out==0) and edge and high_ms ≠ 0: out←1, ms_cnt←0.
  - Firing, on each ms_tick: if ms_cnt ≥ high_ms-1, then out←0, ms_cnt←0, done←1 for one cycle; else ms_cnt++.
  - Edges while firing are ignored.
  - An edge with high_ms == 0 is ignored, and done stays 0.
  - An edge in the same cycle as the ending ms_tick is ignored.
- Channels are fully independent. Only the prescaler is shared.

## Timing
- Reset: tick_cnt, every ms_cnt, pulse_out, done, trig_d are 0. prev_mode←mode.
- Outputs are registered, with no combinational path from inputs to outputs.
- SQUARE/PWM edges occur on the clock edge that ends the ms_tick cycle.
- One-shot timing:
  - pulse_out rises on the edge after the trig rising sample (1-cycle latency).
  - Pulse width is between (high_ms-1)·CNT_MAX+1 and high_ms·CNT_MAX cycles, depending on prescaler phase.
  - done is asserted in the first cycle pulse_out is low after firing.
- Mode change takes effect 1 cycle after the mode input changes.
- Arithmetic:
  - The ms_cnt compares are unsigned MSW-bit.
  - period_ms-1 and high_ms-1 are only evaluated when the operand is nonzero, so they never underflow.
  - tick_cnt width is $clog2(CNT_MAX).
- A reset asserted mid-pulse forces the outputs low on the next edge. There is no done strobe.

## Test plan
Benches use CNT_MAX=10, NUM_CH=4, MSW=16.
1. Reset/idle: assert reset mid-operation with all channels running → next cycle pulse_out=0 and done=0. With mode=00 everywhere, outputs stay 0 for 1000 cycles.
2. SQUARE: period_ms=3 → out toggles every 30 cycles (60-cycle period). Set period_ms=0 → out 0 within 1 cycle. Shrink period from 100 to 2 while ms_cnt=50 → wrap on the next ms_tick.
3. PWM: period_ms=5 and high_ms=2 → high 20 cycles, low 30 cycles, repeating. high_ms=0 → constant 0. high_ms=5 or 9 → constant 1.
4. ONESHOT: high_ms=4; pulse trig at a random prescaler phase → out rises 1 cycle later and stays high 31–40 cycles. done is a single cycle after the fall. A second trig mid-pulse has no effect. trig with high_ms=0 → no pulse, no done.
5. Independence and mode switch: ch0 SQUARE(2), ch1 PWM(4,1), ch2 ONESHOT(3), ch3 OFF run concurrently with the checked waveforms. Switching ch0 SQUARE→PWM mid-half-period → out 0 and ms_cnt 0 for one cycle, then PWM from phase 0.
6. Prescaler: ms_tick spacing is exactly CNT_MAX cycles over 1000 ticks, including across reset release.

Source files
------------

// File: rtl/multi_pulse_gen_if.sv
// Channel config, trigger and output bundle for multi_pulse_gen.
// Latency: none, wiring only. Backpressure: none.
interface multi_pulse_gen_if #(
  parameter int NUM_CH = 4,
  parameter int MSW    = 16
);
  logic [2*NUM_CH-1:0]   mode;
  logic [MSW*NUM_CH-1:0] period_ms;
  logic [MSW*NUM_CH-1:0] high_ms;
  logic [NUM_CH-1:0]     trig;
  logic [NUM_CH-1:0]     pulse_out;
  logic [NUM_CH-1:0]     done;

  modport master (
    output mode, period_ms, high_ms, trig,
    input  pulse_out, done
  );

  modport slave (
    input  mode, period_ms, high_ms, trig,
    output pulse_out, done
  );
endinterface

// File: rtl/multi_pulse_gen.sv
// NUM_CH pulse generators (off/square/PWM/one-shot) sharing one ms prescaler.
// Latency: registered outputs, one-shot rises 1 cycle after trigger. Backpressure: none.
module multi_pulse_gen #(
  parameter int CNT_MAX = 100_000,
  parameter int NUM_CH  = 4,
  parameter int MSW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  multi_pulse_gen_if.slave  bus
);

  localparam int TW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CNT_MAX - 1);

  localparam logic [1:0] MODE_SQUARE  = 2'b01;
  localparam logic [1:0] MODE_PWM     = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          ms_tick;

  always_comb begin
    ms_tick    = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = ms_tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [MSW-1:0] per, hi;
    logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
    logic           out_q, out_d;
    logic           done_q, done_d;
    logic           trig_d_q, trig_d_d;
    logic [1:0]     cur_mode, prev_mode_q, prev_mode_d;
    logic           trig_edge, per_wrap, hi_end;

    assign per      = bus.period_ms[MSW*i +: MSW];
    assign hi       = bus.high_ms[MSW*i +: MSW];
    assign cur_mode = bus.mode[2*i +: 2];

    always_comb begin
      // The minus-one results are only used when the operand is nonzero.
      per_wrap    = (per != '0) && (ms_cnt_q >= per - MSW'(1));
      hi_end      = (hi == '0) || (ms_cnt_q >= hi - MSW'(1));
      trig_edge   = bus.trig[i] & ~trig_d_q;
      ms_cnt_d    = ms_cnt_q;
      out_d       = out_q;
      done_d      = 1'b0;
      trig_d_d    = bus.trig[i];
      prev_mode_d = cur_mode;

      if (cur_mode != prev_mode_q) begin
        ms_cnt_d = '0;
        out_d    = 1'b0;
      end else begin
        case (cur_mode)
          MODE_SQUARE: begin
            if (per == '0) begin
              ms_cnt_d = '0;
              out_d    = 1'b0;
            end else if (ms_tick) begin
              if (per_wrap) begin
                ms_cnt_d = '0;
                out_d    = ~out_q;
              end else begin
                ms_cnt_d = ms_cnt_q + MSW'(1);
              end
            end
          end
          MODE_PWM: begin
            if (per == '0) begin
              ms_cnt_d = '0;
              out_d    = 1'b0;
            end else begin
              if (ms_tick) ms_cnt_d = per_wrap ? '0 : ms_cnt_q + MSW'(1);
              out_d = (ms_cnt_d < hi);
            end
          end
          MODE_ONESHOT: begin
            if (!out_q) begin
              if (trig_edge && (hi != '0)) begin
                out_d    = 1'b1;
                ms_cnt_d = '0;
              end
            end else if (ms_tick) begin
              if (hi_end) begin
                out_d    = 1'b0;
                ms_cnt_d = '0;
                done_d   = 1'b1;
              end else begin
                ms_cnt_d = ms_cnt_q + MSW'(1);
              end
            end
          end
          default: begin
            ms_cnt_d = '0;
            out_d    = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ms_cnt_q    <= '0;
        out_q       <= 1'b0;
        done_q      <= 1'b0;
        trig_d_q    <= 1'b0;
        prev_mode_q <= cur_mode;
      end else begin
        ms_cnt_q    <= ms_cnt_d;
        out_q       <= out_d;
        done_q      <= done_d;
        trig_d_q    <= trig_d_d;
        prev_mode_q <= prev_mode_d;
      end
    end

    assign bus.pulse_out[i] = out_q;
    assign bus.done[i]      = done_q;
  end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Scoreboard bench for multi_pulse_gen: expected output edges and done strobes are queued per channel.
module tb_multi_pulse_gen;
  localparam int CNT_MAX = 10;
  localparam int NUM_CH  = 4;
  localparam int MSW     = 16;

  localparam logic [1:0] M_OFF = 2'b00, M_SQ = 2'b01, M_PWM = 2'b10, M_ONE = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  multi_pulse_gen_if #(.NUM_CH(NUM_CH), .MSW(MSW)) bus ();

  multi_pulse_gen #(.CNT_MAX(CNT_MAX), .NUM_CH(NUM_CH), .MSW(MSW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    bit is_done;
    bit val;
  } ev_t;

  ev_t exp_q[NUM_CH][$];
  int  errors = 0;
  int  checks = 0;
  int  edge_n = 0;
  int  r_edge = 0;
  bit  mon_en = 1'b0;
  int  drain_req = 0;
  int  drain_done = 0;
  logic [NUM_CH-1:0] last = '0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every output change or done strobe must match the head of its channel queue.
  task automatic score(int ch, bit is_done, logic val);
    ev_t e;
    checks++;
    if (exp_q[ch].size() == 0) begin
      errors++;
      $display("FAIL ch%0d %s: got %b at edge %0d, required no event", ch,
               is_done ? "done" : "pulse_out", val, edge_n);
    end else begin
      e = exp_q[ch].pop_front();
      if (e.at != edge_n || e.val !== val || e.is_done != is_done) begin
        errors++;
        $display("FAIL ch%0d %s: got %b at edge %0d, required %s=%b at edge %0d", ch,
                 is_done ? "done" : "pulse_out", val, edge_n,
                 e.is_done ? "done" : "pulse_out", e.val, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (bus.pulse_out[ch] !== last[ch]) begin
          score(ch, 1'b0, bus.pulse_out[ch]);
          last[ch] = bus.pulse_out[ch];
        end
        if (bus.done[ch] !== 1'b0) score(ch, 1'b1, bus.done[ch]);
      end
      if (drain_done != drain_req) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          checks++;
          if (exp_q[ch].size() != 0) begin
            errors++;
            $display("FAIL ch%0d missing: %0d events outstanding, next required at edge %0d",
                     ch, exp_q[ch].size(), exp_q[ch][0].at);
            exp_q[ch].delete();
          end
        end
        drain_done++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_edge(int e);
    while (edge_n < e) step(1);
  endtask

  task automatic align();
    while ((edge_n - r_edge) % CNT_MAX != CNT_MAX - 1) step(1);
  endtask

  function automatic int next_tick(int e);
    return r_edge + CNT_MAX * ((e - r_edge) / CNT_MAX + 1);
  endfunction

  task automatic drain();
    step(2);
    drain_req++;
    step(1);
  endtask

  task automatic exp_ev(int ch, int at, bit is_done, bit val);
    ev_t e;
    e.at = at;
    e.is_done = is_done;
    e.val = val;
    exp_q[ch].push_back(e);
  endtask

  task automatic set_mode(int ch, logic [1:0] m);
    bus.mode[2*ch +: 2] = m;
  endtask

  task automatic set_cfg(int ch, int per, int hi);
    bus.period_ms[MSW*ch +: MSW] = MSW'(per);
    bus.high_ms[MSW*ch +: MSW]   = MSW'(hi);
  endtask

  task automatic set_per(int ch, int per);
    bus.period_ms[MSW*ch +: MSW] = MSW'(per);
  endtask

  task automatic set_hi(int ch, int hi);
    bus.high_ms[MSW*ch +: MSW] = MSW'(hi);
  endtask

  initial begin
    int s, t1, g, h, f, r;
    bus.mode = '0;
    bus.period_ms = '0;
    bus.high_ms = '0;
    bus.trig = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    r_edge = edge_n;
    mon_en = 1'b1;

    // Idle: all channels off, no events at all.
    step(1000);
    drain();

    // Square period 3, then period 0, then shrink 100 -> 2 at ms_cnt = 50.
    set_per(0, 3);
    align();
    s = edge_n;
    t1 = s + 11;
    set_mode(0, M_SQ);
    exp_ev(0, t1 + 20, 0, 1);
    exp_ev(0, t1 + 50, 0, 0);
    exp_ev(0, t1 + 80, 0, 1);
    exp_ev(0, t1 + 91, 0, 0);
    goto_edge(t1 + 90);
    set_per(0, 0);
    goto_edge(t1 + 95);
    set_per(0, 100);
    goto_edge(t1 + 590);
    set_per(0, 2);
    exp_ev(0, t1 + 600, 0, 1);
    exp_ev(0, t1 + 620, 0, 0);
    goto_edge(t1 + 625);
    set_mode(0, M_OFF);
    drain();

    // PWM 5/2, then high 0, 5, 9.
    set_cfg(1, 5, 2);
    align();
    s = edge_n;
    t1 = s + 11;
    set_mode(1, M_PWM);
    exp_ev(1, s + 2, 0, 1);
    exp_ev(1, t1 + 10, 0, 0);
    exp_ev(1, t1 + 40, 0, 1);
    exp_ev(1, t1 + 60, 0, 0);
    exp_ev(1, t1 + 90, 0, 1);
    exp_ev(1, t1 + 110, 0, 0);
    goto_edge(t1 + 115);
    set_hi(1, 0);
    step(100);
    h = edge_n;
    exp_ev(1, h + 1, 0, 1);
    set_hi(1, 5);
    goto_edge(h + 100);
    set_hi(1, 9);
    step(100);
    f = edge_n;
    exp_ev(1, f + 1, 0, 0);
    set_mode(1, M_OFF);
    drain();

    // One-shot 4 ms at a random prescaler phase, retrigger ignored, high 0 ignored.
    set_hi(2, 4);
    align();
    s = edge_n;
    set_mode(2, M_ONE);
    step(1 + $urandom_range(0, 9));
    g = edge_n;
    t1 = next_tick(g + 1);
    exp_ev(2, g + 1, 0, 1);
    exp_ev(2, t1 + 30, 0, 0);
    exp_ev(2, t1 + 30, 1, 1);
    bus.trig[2] = 1'b1;
    step(1);
    bus.trig[2] = 1'b0;
    goto_edge(g + 14);
    bus.trig[2] = 1'b1;
    step(1);
    bus.trig[2] = 1'b0;
    goto_edge(t1 + 29);
    bus.trig[2] = 1'b1;
    step(1);
    bus.trig[2] = 1'b0;
    goto_edge(t1 + 40);
    set_hi(2, 0);
    step(5);
    bus.trig[2] = 1'b1;
    step(1);
    bus.trig[2] = 1'b0;
    step(60);
    set_mode(2, M_OFF);
    step(5);
    drain();

    // Concurrent channels, then ch0 square -> PWM mid half-period.
    set_cfg(0, 2, 1);
    set_cfg(1, 4, 1);
    set_cfg(2, 0, 3);
    set_cfg(3, 1, 1);
    align();
    s = edge_n;
    t1 = s + 11;
    set_mode(0, M_SQ);
    set_mode(1, M_PWM);
    set_mode(2, M_ONE);
    exp_ev(0, t1 + 10, 0, 1);
    exp_ev(0, t1 + 30, 0, 0);
    exp_ev(0, t1 + 50, 0, 1);
    exp_ev(0, t1 + 56, 0, 0);
    exp_ev(0, t1 + 57, 0, 1);
    exp_ev(0, t1 + 60, 0, 0);
    exp_ev(0, t1 + 70, 0, 1);
    exp_ev(0, t1 + 80, 0, 0);
    exp_ev(1, s + 2, 0, 1);
    exp_ev(1, t1, 0, 0);
    exp_ev(1, t1 + 30, 0, 1);
    exp_ev(1, t1 + 40, 0, 0);
    exp_ev(1, t1 + 70, 0, 1);
    exp_ev(1, t1 + 80, 0, 0);
    exp_ev(2, s + 4, 0, 1);
    exp_ev(2, s + 31, 0, 0);
    exp_ev(2, s + 31, 1, 1);
    goto_edge(s + 3);
    bus.trig = 4'b1100;
    step(1);
    bus.trig = '0;
    goto_edge(t1 + 55);
    set_mode(0, M_PWM);
    goto_edge(t1 + 85);
    bus.mode = '0;
    step(5);
    drain();

    // Reset mid-operation with every channel high.
    set_cfg(0, 1, 0);
    set_cfg(1, 4, 4);
    set_cfg(2, 0, 4);
    set_cfg(3, 1, 0);
    align();
    s = edge_n;
    t1 = s + 11;
    bus.mode = {M_SQ, M_ONE, M_PWM, M_SQ};
    exp_ev(0, t1, 0, 1);
    exp_ev(0, t1 + 10, 0, 0);
    exp_ev(0, t1 + 20, 0, 1);
    exp_ev(3, t1, 0, 1);
    exp_ev(3, t1 + 10, 0, 0);
    exp_ev(3, t1 + 20, 0, 1);
    exp_ev(1, s + 2, 0, 1);
    exp_ev(2, s + 4, 0, 1);
    for (int ch = 0; ch < NUM_CH; ch++) exp_ev(ch, t1 + 26, 0, 0);
    goto_edge(s + 3);
    bus.trig[2] = 1'b1;
    step(1);
    bus.trig[2] = 1'b0;
    goto_edge(t1 + 25);
    reset = 1'b1;
    bus.mode = '0;
    step(1);
    reset = 1'b0;
    r_edge = edge_n;
    step(200);
    drain();

    // Prescaler spacing over 1000 ticks starting at reset release (square period 1).
    set_per(0, 1);
    set_mode(0, M_SQ);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    r_edge = edge_n;
    r = r_edge;
    for (int k = 1; k <= 1000; k++) exp_ev(0, r + CNT_MAX * k, 0, k[0]);
    goto_edge(r + CNT_MAX * 1000 + 5);
    set_mode(0, M_OFF);
    step(5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
